// File: rtl/rst_vector_sequencer.sv
// rst_vector_sequencer
//   Sequences an RST-opcode (or optional interrupt) entry: pushes the latched PC high byte,
//   then the low byte, then issues a single-cycle PC load to the selected vector.
//
// Configuration macro: RST_SEQ_IRQ_EN
//   defined   -> irq_req/irq_enable can start a sequence, irq_ack pulses during LOAD.
//   undefined -> only RST opcodes start sequences; irq inputs ignored, irq_ack stays 0.
//
// Ports
//   clk              clock, all state changes on its rising edge
//   not_reset        asynchronous active-low reset
//   not_decodingIn   decode-chain enable in (active low)
//   notCINT0_RST     RST opcode-class hit (active low)
//   OP5_3/notOP5_3   opcode bits 5:3 and their complement (OP5_3 selects the vector)
//   not_isXPT12      prefix qualifier (active low)
//   irq_req          level-sensitive interrupt requests, channel 0 has priority
//   irq_enable       global interrupt enable
//   pc               program counter, sampled when a sequence starts
//   push_ready       stack-write acceptance
//   not_decodingOut  decode-chain enable out (active low), high when claimed or busy
//   push_valid/push_data  stack-write strobe and byte
//   pc_load/pc_vector     PC load strobe and target
//   irq_ack          one-hot acknowledge, one cycle in LOAD for interrupt sequences
//   busy             high whenever a sequence is in progress
module rst_vector_sequencer #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned IRQ_BASE_IDX = 4,
  parameter int unsigned VEC_SHIFT    = 3
) (
  input  logic               clk,
  input  logic               not_reset,
  input  logic               not_decodingIn,
  input  logic               notCINT0_RST,
  input  logic [2:0]         OP5_3,
  input  logic [2:0]         notOP5_3,
  input  logic               not_isXPT12,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               irq_enable,
  input  logic [15:0]        pc,
  input  logic               push_ready,
  output logic               not_decodingOut,
  output logic               push_valid,
  output logic [7:0]         push_data,
  output logic               pc_load,
  output logic [15:0]        pc_vector,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StPushHi, StPushLo, StLoad} state_e;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [15:0]          pc_q, pc_d;
  logic [NUM_IRQ-1:0]   chan_q, chan_d;
  logic                 src_irq_q, src_irq_d;

  logic                 push_valid_q, push_valid_d;
  logic [7:0]           push_data_q, push_data_d;
  logic                 pc_load_q, pc_load_d;
  logic [15:0]          pc_vector_q, pc_vector_d;
  logic [NUM_IRQ-1:0]   irq_ack_q, irq_ack_d;

  logic                 hit;
  logic                 irq_start;
  logic [NUM_IRQ-1:0]   irq_sel;
  logic [2:0]           irq_idx;

  // The complement opcode bits carry no extra information for vector selection.
  logic unused_notop;
  assign unused_notop = ^notOP5_3;

  assign busy            = (state_q != StIdle);
  assign hit             = ~not_decodingIn & ~notCINT0_RST & ~not_isXPT12 & (state_q == StIdle);
  assign not_decodingOut = not_decodingIn | hit | busy;

`ifdef RST_SEQ_IRQ_EN
  logic irq_any;

  // Descending scan so the lowest-numbered pending channel wins.
  always_comb begin
    irq_any = 1'b0;
    irq_sel = '0;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        irq_any    = 1'b1;
        irq_sel    = '0;
        irq_sel[i] = 1'b1;
        irq_idx    = 3'((IRQ_BASE_IDX + i) % 8);
      end
    end
  end

  assign irq_start = irq_enable & irq_any;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_req, irq_enable};
  assign irq_start  = 1'b0;
  assign irq_sel    = '0;
  assign irq_idx    = '0;
`endif

  // Next-state and latch update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pc_d      = pc_q;
    chan_d    = chan_q;
    src_irq_d = src_irq_q;
    case (state_q)
      StIdle: begin
        // RST opcode takes priority; a coincident interrupt stays pending.
        if (hit) begin
          idx_d     = OP5_3;
          pc_d      = pc;
          chan_d    = '0;
          src_irq_d = 1'b0;
          state_d   = StPushHi;
        end else if (irq_start) begin
          idx_d     = irq_idx;
          pc_d      = pc;
          chan_d    = irq_sel;
          src_irq_d = 1'b1;
          state_d   = StPushHi;
        end
      end
      StPushHi: if (push_ready) state_d = StPushLo;
      StPushLo: if (push_ready) state_d = StLoad;
      StLoad:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered: derive them from the state being entered.
  always_comb begin
    push_valid_d = (state_d == StPushHi) || (state_d == StPushLo);
    push_data_d  = '0;
    if (state_d == StPushHi) begin
      push_data_d = pc_d[15:8];
    end else if (state_d == StPushLo) begin
      push_data_d = pc_d[7:0];
    end
    pc_load_d   = (state_d == StLoad);
    pc_vector_d = '0;
    irq_ack_d   = '0;
    if (state_d == StLoad) begin
      pc_vector_d = 16'(idx_d) << VEC_SHIFT;
      if (src_irq_d) begin
        irq_ack_d = chan_d;
      end
    end
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pc_q         <= '0;
      chan_q       <= '0;
      src_irq_q    <= 1'b0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      pc_load_q    <= 1'b0;
      pc_vector_q  <= '0;
      irq_ack_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pc_q         <= pc_d;
      chan_q       <= chan_d;
      src_irq_q    <= src_irq_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      pc_load_q    <= pc_load_d;
      pc_vector_q  <= pc_vector_d;
      irq_ack_q    <= irq_ack_d;
    end
  end

  assign push_valid = push_valid_q;
  assign push_data  = push_data_q;
  assign pc_load    = pc_load_q;
  assign pc_vector  = pc_vector_q;
  assign irq_ack    = irq_ack_q;

endmodule
